// File: rtl/cntx_seq_pkg.sv
// cntx_seq_pkg: shared state encoding, default line geometry and status bit indices
package cntx_seq_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_SOF, ST_PASS, ST_PAD, ST_DROP, ST_FLUSH} state_t;
  localparam int GROUPS = 3840 / 4;
  localparam int ERR_LINE = 0;
  localparam int ERR_FRAME = 1;
  localparam int ERR_TIMEOUT = 2;
  function automatic int groups_of(input int width, input int spc);
    return width / spc;
  endfunction
endpackage

// File: rtl/cntx_frame_sequencer.sv
// cntx_frame_sequencer: admits whole frames to the context generator, pads broken frames and holds off input during border flush
module cntx_frame_sequencer
  import cntx_seq_pkg::*;
#(
  parameter int SAMPLES_PER_CLOCK = 4,
  parameter int BITS_PER_PIXEL = 8,
  parameter int TDATA_WIDTH = SAMPLES_PER_CLOCK * BITS_PER_PIXEL,
  parameter int WIDTH = 3840,
  parameter int HEIGHT = 2160,
  parameter int W_POSITION_WIDTH = 10,
  parameter int H_POSITION_WIDTH = 12,
  parameter int TIMEOUT_WIDTH = 21
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_aresetn,
  input  logic                   enable,
  input  logic                   err_clear,
  input  logic [TDATA_WIDTH-1:0] VIDEO_IN_tdata,
  input  logic                   VIDEO_IN_tuser,
  input  logic                   VIDEO_IN_tlast,
  input  logic                   VIDEO_IN_tvalid,
  output logic                   VIDEO_IN_tready,
  output logic [TDATA_WIDTH-1:0] gen_tdata,
  output logic                   gen_tuser,
  output logic                   gen_tlast,
  output logic                   gen_tvalid,
  input  logic                   gen_tready,
  input  logic                   ctx_tvalid,
  input  logic                   ctx_tlast,
  input  logic                   cons_tready,
  output logic                   ctx_tready,
  output logic                   busy,
  output logic                   err_line,
  output logic                   err_frame,
  output logic                   err_timeout,
  output logic [15:0]            frame_cnt
);
  localparam int NG = groups_of(WIDTH, SAMPLES_PER_CLOCK);
  localparam logic [W_POSITION_WIDTH-1:0] GRP_LAST = W_POSITION_WIDTH'(NG - 1);
  localparam logic [H_POSITION_WIDTH-1:0] LINE_LAST = H_POSITION_WIDTH'(HEIGHT - 1);
  localparam logic [H_POSITION_WIDTH-1:0] LINES = H_POSITION_WIDTH'(HEIGHT);
  state_t state, state_nx;
  logic [W_POSITION_WIDTH-1:0] grp, grp_nx;
  logic [H_POSITION_WIDTH-1:0] line, line_nx, out_lines;
  logic [TIMEOUT_WIDTH-1:0] wdog;
  logic [2:0] err, err_set;
  logic full, at_last, sof, frame_bad, ctx_line, lines_done, wd_max, flush_exit;
  assign full = grp == GRP_LAST;
  assign at_last = line == LINE_LAST;
  assign sof = VIDEO_IN_tvalid & VIDEO_IN_tuser;
  assign frame_bad = sof & (grp != '0 | line != '0);
  assign ctx_line = ctx_tvalid & cons_tready & ctx_tlast;
  assign lines_done = out_lines == LINES;
  assign wd_max = &wdog;
  assign flush_exit = state == ST_FLUSH & (lines_done | wd_max);
  assign ctx_tready = cons_tready;
  assign busy = state != ST_IDLE & state != ST_WAIT_SOF;
  assign err_line = err[ERR_LINE];
  assign err_frame = err[ERR_FRAME];
  assign err_timeout = err[ERR_TIMEOUT];
  always_comb begin
    state_nx = state;
    grp_nx = grp;
    line_nx = line;
    err_set = '0;
    VIDEO_IN_tready = 1'b0;
    gen_tvalid = 1'b0;
    gen_tdata = '0;
    gen_tuser = 1'b0;
    gen_tlast = full;
    case (state)
      ST_IDLE: state_nx = enable ? ST_WAIT_SOF : ST_IDLE;
      ST_WAIT_SOF: begin
        VIDEO_IN_tready = !sof;
        if (sof) begin
          state_nx = ST_PASS;
          grp_nx = '0;
          line_nx = '0;
        end
      end
      ST_PASS: begin
        VIDEO_IN_tready = gen_tready;
        gen_tvalid = VIDEO_IN_tvalid & !frame_bad;
        gen_tdata = VIDEO_IN_tdata;
        gen_tuser = VIDEO_IN_tuser;
        if (VIDEO_IN_tvalid & gen_tready) begin
          if (frame_bad) begin
            err_set[ERR_FRAME] = 1'b1;
            state_nx = ST_PAD;
          end else begin
            err_set[ERR_LINE] = VIDEO_IN_tlast != full;
            grp_nx = full ? '0 : grp + 1'b1;
            line_nx = line + H_POSITION_WIDTH'(full);
            state_nx = full ? (at_last ? ST_FLUSH : ST_PASS) : (VIDEO_IN_tlast ? ST_PAD : ST_PASS);
          end
        end
      end
      ST_PAD: begin
        gen_tvalid = 1'b1;
        if (gen_tready) begin
          grp_nx = full ? '0 : grp + 1'b1;
          line_nx = line + H_POSITION_WIDTH'(full);
          state_nx = full & at_last ? ST_DROP : ST_PAD;
        end
      end
      ST_DROP: begin
        VIDEO_IN_tready = !sof;
        state_nx = sof ? ST_FLUSH : ST_DROP;
      end
      ST_FLUSH: if (flush_exit) begin
        err_set[ERR_TIMEOUT] = !lines_done;
        state_nx = enable ? ST_WAIT_SOF : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state <= ST_IDLE;
      grp <= '0;
      line <= '0;
      out_lines <= '0;
      wdog <= '0;
      err <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      grp <= grp_nx;
      line <= line_nx;
      out_lines <= (state == ST_WAIT_SOF & state_nx == ST_PASS) ? '0 : out_lines + H_POSITION_WIDTH'(ctx_line & !lines_done);
      wdog <= (ctx_line | (state_nx == ST_FLUSH & state != ST_FLUSH)) ? '0 : wdog + TIMEOUT_WIDTH'(state == ST_FLUSH);
      err <= (err & ~{3{err_clear}}) | err_set;
      frame_cnt <= frame_cnt + 16'(flush_exit);
    end
  end
endmodule

// File: tb/tb_cntx_frame_sequencer.sv
// tb_cntx_frame_sequencer: randomized frame streams checked against a frame-level reference model
module tb_cntx_frame_sequencer;
  localparam int SPC = 4;
  localparam int TDW = 32;
  localparam int WIDTH = 16;
  localparam int HEIGHT = 4;
  localparam int TW = 6;
  localparam int G = WIDTH / SPC;
  localparam int NPIX = G * HEIGHT;
  typedef struct packed {logic [TDW-1:0] data; logic user; logic last;} beat_t;
  logic clk = 1'b0;
  logic s_axis_aresetn = 1'b0;
  logic enable = 1'b0;
  logic err_clear = 1'b0;
  logic [TDW-1:0] VIDEO_IN_tdata = '0;
  logic VIDEO_IN_tuser = 1'b0;
  logic VIDEO_IN_tlast = 1'b0;
  logic VIDEO_IN_tvalid = 1'b0;
  logic VIDEO_IN_tready;
  logic [TDW-1:0] gen_tdata;
  logic gen_tuser, gen_tlast, gen_tvalid;
  logic gen_tready = 1'b1;
  logic ctx_tvalid = 1'b0;
  logic ctx_tlast = 1'b0;
  logic cons_tready = 1'b1;
  logic ctx_tready, busy, err_line, err_frame, err_timeout;
  logic [15:0] frame_cnt;
  int checks = 0;
  int failures = 0;
  beat_t up_q[$], stim[$], exp_q[$], got_q[$];
  int pending = 0;
  bit ctx_en = 1'b1;
  bit rnd_gready, rnd_cons, rnd_bubble;
  bit exp_el, exp_ef;
  int exp_frames;
  always #5 clk = ~clk;
  cntx_frame_sequencer #(
    .SAMPLES_PER_CLOCK(SPC), .BITS_PER_PIXEL(8), .TDATA_WIDTH(TDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .W_POSITION_WIDTH(10), .H_POSITION_WIDTH(12), .TIMEOUT_WIDTH(TW)
  ) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(s_axis_aresetn), .enable(enable), .err_clear(err_clear),
    .VIDEO_IN_tdata(VIDEO_IN_tdata), .VIDEO_IN_tuser(VIDEO_IN_tuser), .VIDEO_IN_tlast(VIDEO_IN_tlast),
    .VIDEO_IN_tvalid(VIDEO_IN_tvalid), .VIDEO_IN_tready(VIDEO_IN_tready),
    .gen_tdata(gen_tdata), .gen_tuser(gen_tuser), .gen_tlast(gen_tlast), .gen_tvalid(gen_tvalid),
    .gen_tready(gen_tready), .ctx_tvalid(ctx_tvalid), .ctx_tlast(ctx_tlast), .cons_tready(cons_tready),
    .ctx_tready(ctx_tready), .busy(busy), .err_line(err_line), .err_frame(err_frame),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );
  task automatic cycle();
    bit uh, gh, ch;
    beat_t b;
    @(negedge clk);
    uh = VIDEO_IN_tvalid && VIDEO_IN_tready;
    gh = gen_tvalid && gen_tready;
    ch = ctx_tvalid && cons_tready && ctx_tlast;
    if (gh) begin
      b.data = gen_tdata;
      b.user = gen_tuser;
      b.last = gen_tlast;
      got_q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (uh) void'(up_q.pop_front());
    if (uh || !VIDEO_IN_tvalid) VIDEO_IN_tvalid = (up_q.size() > 0) && (!rnd_bubble || $urandom_range(0, 3) != 0);
    if (VIDEO_IN_tvalid) {VIDEO_IN_tdata, VIDEO_IN_tuser, VIDEO_IN_tlast} = up_q[0];
    if (gh && b.last && ctx_en) pending++;
    if (ch) pending--;
    if (ch || !ctx_tvalid) ctx_tvalid = (pending > 0) && $urandom_range(0, 1) == 1;
    ctx_tlast = ctx_tvalid;
    gen_tready = rnd_gready ? $urandom_range(0, 1) == 1 : 1'b1;
    cons_tready = rnd_cons ? $urandom_range(0, 1) == 1 : 1'b1;
  endtask
  task automatic do_reset();
    s_axis_aresetn = 1'b0;
    VIDEO_IN_tvalid = 1'b0;
    ctx_tvalid = 1'b0;
    ctx_tlast = 1'b0;
    gen_tready = 1'b1;
    cons_tready = 1'b1;
    err_clear = 1'b0;
    pending = 0;
    ctx_en = 1'b1;
    rnd_gready = 1'b0;
    rnd_cons = 1'b0;
    rnd_bubble = 1'b0;
    up_q.delete();
    stim.delete();
    got_q.delete();
    repeat (2) @(posedge clk);
    #1 s_axis_aresetn = 1'b1;
  endtask
  task automatic push_line(input bit sof, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = $urandom;
      b.user = sof && k == 0;
      b.last = k == len - 1;
      stim.push_back(b);
    end
  endtask
  task automatic push_frame();
    for (int l = 0; l < HEIGHT; l++) push_line(l == 0, G);
  endtask
  task automatic push_junk(input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = $urandom;
      b.user = 1'b0;
      b.last = $urandom_range(0, 1) == 1;
      stim.push_back(b);
    end
  endtask
  // Expected generator beats: each frame is a fixed grid of NPIX beats, filled from upstream until
  // something breaks, then zero-padded; the rest of upstream is skipped up to the next start of frame.
  task automatic model();
    int i, n, p;
    bit bad;
    beat_t b, o;
    i = 0;
    n = stim.size();
    exp_q.delete();
    exp_el = 1'b0;
    exp_ef = 1'b0;
    exp_frames = 0;
    forever begin
      while (i < n && !stim[i].user) i++;
      if (i >= n) break;
      p = 0;
      bad = 1'b0;
      while (p < NPIX && i < n && !bad) begin
        b = stim[i];
        i++;
        if (b.user && p != 0) begin
          exp_ef = 1'b1;
          bad = 1'b1;
        end else begin
          o.data = b.data;
          o.user = b.user;
          o.last = p % G == G - 1;
          exp_q.push_back(o);
          if (b.last != o.last) begin
            exp_el = 1'b1;
            bad = !o.last;
          end
          p++;
        end
      end
      if (p < NPIX && !bad) break;
      for (; p < NPIX; p++) begin
        o = '0;
        o.last = p % G == G - 1;
        exp_q.push_back(o);
      end
      if (bad) begin
        while (i < n && !stim[i].user) i++;
        if (i < n) exp_frames++;
      end else exp_frames++;
    end
  endtask
  task automatic run_stream(input string name, input bit exp_to, input int drop_at);
    int budget, mm;
    model();
    up_q = stim;
    got_q.delete();
    budget = 0;
    while ((frame_cnt != 16'(exp_frames) || up_q.size() != 0) && budget < 5000) begin
      cycle();
      budget++;
      if (budget == drop_at) enable = 1'b0;
    end
    repeat (6) cycle();
    checks++;
    if (budget >= 5000) begin
      failures++;
      $display("FAIL %s wait: frame_cnt=%0d queue=%0d want frames=%0d queue=0", name, frame_cnt, up_q.size(), exp_frames);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s beat_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    mm = -1;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) if (mm < 0 && got_q[k] !== exp_q[k]) mm = k;
    checks++;
    if (mm >= 0) begin
      failures++;
      $display("FAIL %s beat[%0d]: got data=%h user=%b last=%b want data=%h user=%b last=%b", name, mm,
               got_q[mm].data, got_q[mm].user, got_q[mm].last, exp_q[mm].data, exp_q[mm].user, exp_q[mm].last);
    end
    checks++;
    if (err_line !== exp_el) begin
      failures++;
      $display("FAIL %s err_line: got %b want %b", name, err_line, exp_el);
    end
    checks++;
    if (err_frame !== exp_ef) begin
      failures++;
      $display("FAIL %s err_frame: got %b want %b", name, err_frame, exp_ef);
    end
    checks++;
    if (err_timeout !== exp_to) begin
      failures++;
      $display("FAIL %s err_timeout: got %b want %b", name, err_timeout, exp_to);
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL %s frame_cnt: got %0d want %0d", name, frame_cnt, exp_frames);
    end
  endtask
  task automatic test_reset();
    enable = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if ({VIDEO_IN_tready, gen_tvalid, gen_tuser, gen_tlast, gen_tdata} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got tready=%b gvalid=%b guser=%b glast=%b gdata=%h want all 0",
               VIDEO_IN_tready, gen_tvalid, gen_tuser, gen_tlast, gen_tdata);
    end
    checks++;
    if ({busy, err_line, err_frame, err_timeout} !== 4'b0 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset status: got busy=%b errs=%b%b%b frames=%0d want 0", busy, err_line, err_frame, err_timeout, frame_cnt);
    end
    for (int v = 0; v < 2; v++) begin
      cons_tready = v[0];
      #1;
      checks++;
      if (ctx_tready !== cons_tready) begin
        failures++;
        $display("FAIL ctx_tready: got %b want %b", ctx_tready, cons_tready);
      end
    end
    cons_tready = 1'b1;
    enable = 1'b1;
    cycle();
    cycle();
    checks++;
    if (VIDEO_IN_tready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_sof: got tready=%b busy=%b want 1 0", VIDEO_IN_tready, busy);
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    push_frame();
    up_q = stim;
    repeat (8) cycle();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midframe busy: got %b want 1", busy);
    end
    @(posedge clk);
    #2 s_axis_aresetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || gen_tvalid !== 1'b0 || VIDEO_IN_tready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b gvalid=%b tready=%b want 0 0 0", busy, gen_tvalid, VIDEO_IN_tready);
    end
  endtask
  task automatic test_clean();
    do_reset();
    push_frame();
    run_stream("clean", 1'b0, -1);
  endtask
  task automatic test_junk();
    do_reset();
    push_junk(3);
    push_frame();
    run_stream("junk", 1'b0, -1);
    checks++;
    if (got_q.size() == 0 || got_q[0].user !== 1'b1) begin
      failures++;
      $display("FAIL junk first_user: got %b want 1", got_q.size() ? got_q[0].user : 1'bx);
    end
  endtask
  task automatic test_line_err();
    do_reset();
    push_line(1, G);
    push_line(0, G);
    push_line(0, 2);
    push_line(0, G);
    push_frame();
    run_stream("line_err", 1'b0, -1);
  endtask
  task automatic test_frame_err();
    do_reset();
    push_line(1, G);
    push_frame();
    push_frame();
    run_stream("frame_err", 1'b0, -1);
  endtask
  task automatic test_timeout();
    do_reset();
    ctx_en = 1'b0;
    push_frame();
    run_stream("timeout", 1'b1, -1);
    checks++;
    if (busy !== 1'b0 || VIDEO_IN_tready !== 1'b1) begin
      failures++;
      $display("FAIL timeout end_state: got busy=%b tready=%b want 0 1", busy, VIDEO_IN_tready);
    end
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: got %b want 0", err_timeout);
    end
    ctx_en = 1'b1;
  endtask
  task automatic test_enable_drop();
    do_reset();
    rnd_gready = 1'b1;
    push_frame();
    run_stream("enable_drop", 1'b0, 10);
    checks++;
    if (busy !== 1'b0 || VIDEO_IN_tready !== 1'b0) begin
      failures++;
      $display("FAIL enable_drop idle: got busy=%b tready=%b want 0 0", busy, VIDEO_IN_tready);
    end
    enable = 1'b1;
  endtask
  task automatic test_random(input int seed_round);
    int kind;
    do_reset();
    rnd_gready = 1'b1;
    rnd_cons = 1'b1;
    rnd_bubble = 1'b1;
    for (int f = 0; f < 6; f++) begin
      push_junk($urandom_range(0, 2));
      for (int l = 0; l < HEIGHT; l++) begin
        kind = $urandom_range(0, 11);
        if (kind == 0) push_line(l == 0, 2);
        else if (kind == 1) push_line(l == 0, G + 1);
        else if (kind == 2) push_line(1, G);
        else push_line(l == 0, G);
      end
    end
    push_frame();
    push_frame();
    run_stream($sformatf("random%0d", seed_round), 1'b0, -1);
  endtask
  initial begin
    test_reset();
    test_async_reset();
    enable = 1'b1;
    test_clean();
    test_junk();
    test_line_err();
    test_frame_err();
    test_timeout();
    test_enable_drop();
    for (int r = 0; r < 3; r++) test_random(r);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
